// File: rtl/wb_scheduler_pkg.sv
// Shared writeback definitions: mux select encodings, register address width
// and the load-return record carried through the return FIFO.
package wb_scheduler_pkg;

    localparam int REG_AW = 5;

    localparam logic [1:0] WB_LOAD = 2'b00;
    localparam logic [1:0] WB_ALU  = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [31:0]       data;
    } ld_ret_t;

endpackage

// File: rtl/wb_ret_fifo.sv
// Generic synchronous FIFO with full/empty flags, head always visible.
// Latency: one cycle from push to head; head is combinational from storage.
// Backpressure: push ignored when full unless a pop happens in the same cycle.
module wb_ret_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers are exactly AW bits wide, so DEPTH being a power of two gives the wrap for free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_scheduler.sv
// Register-file write-port arbiter between pipeline writebacks and buffered load returns, with a load scoreboard.
// Latency: grant and write are combinational in the cycle of request; a load return writes no earlier than the next cycle.
// Backpressure: wb_stall holds MEM/WB, raw_stall holds IF/ID, lsu_rready deasserts when the return FIFO is full.
module wb_scheduler
    import wb_scheduler_pkg::*;
#(
    parameter int FIFO_DEPTH      = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_issue,
    input  logic [REG_AW-1:0] ld_issue_rd,
    output logic              ld_issue_ready,
    input  logic              lsu_rvalid,
    input  logic [REG_AW-1:0] lsu_rd,
    input  logic [31:0]       lsu_rdata,
    output logic              lsu_rready,
    input  logic              wb_req,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [1:0]        wb_src,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    output logic [1:0]        wb_sel,
    output logic [31:0]       ld_wdata,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic              wb_stall,
    output logic              raw_stall,
    output logic [2:0]        pending_cnt
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    ld_ret_t     ret_in;
    ld_ret_t     head;
    logic        fifo_full;
    logic        fifo_empty;
    logic        ld_gnt;
    logic        pipe_gnt;
    logic        waw;
    logic        issue_acc;
    logic [31:0] pending_q;
    logic [31:0] pending_nxt;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_nxt;
    logic [SW-1:0] starve_q;

    assign ret_in = '{rd: lsu_rd, data: lsu_rdata};

    wb_ret_fifo #(
        .WIDTH ($bits(ld_ret_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_ret_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (lsu_rvalid && lsu_rready),
        .push_dat (ret_in),
        .pop      (ld_gnt),
        .head_dat (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign lsu_rready = !fifo_full;

    // A full FIFO or a starved head always wins; otherwise the in-order pipe has priority.
    assign ld_gnt   = !fifo_empty && (fifo_full || !wb_req || starve_q == SW'(STARVE_LIMIT));
    assign waw      = wb_req && (wb_rd != '0) && pending_q[wb_rd];
    assign pipe_gnt = !rst && !ld_gnt && wb_req && !waw;
    assign wb_stall = !rst && wb_req && !pipe_gnt;

    assign raw_stall = ((id_rs1 != '0) && pending_q[id_rs1]) ||
                       ((id_rs2 != '0) && pending_q[id_rs2]);

    assign ld_issue_ready = (int'(cnt_q) < MAX_OUTSTANDING) && !pending_q[ld_issue_rd];
    assign issue_acc      = ld_issue && ld_issue_ready;
    assign ld_wdata       = fifo_empty ? '0 : head.data;
    assign pending_cnt    = 3'(cnt_q);

    always_comb begin
        wb_sel   = WB_ALU;
        rf_we    = 1'b0;
        rf_waddr = '0;
        if (ld_gnt) begin
            wb_sel   = WB_LOAD;
            rf_we    = (head.rd != '0);
            rf_waddr = head.rd;
        end else if (pipe_gnt) begin
            wb_sel   = wb_src;
            rf_we    = (wb_rd != '0);
            rf_waddr = wb_rd;
        end
    end

    // Set after clear so a same-cycle reissue to the retiring register stays pending.
    always_comb begin
        pending_nxt = pending_q;
        if (ld_gnt) pending_nxt[head.rd] = 1'b0;
        if (issue_acc && ld_issue_rd != '0) pending_nxt[ld_issue_rd] = 1'b1;
    end

    always_comb begin
        cnt_nxt = cnt_q;
        if (issue_acc && !ld_gnt) begin
            cnt_nxt = cnt_q + 1'b1;
        end else if (ld_gnt && !issue_acc && cnt_q != '0) begin
            cnt_nxt = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            cnt_q     <= '0;
            starve_q  <= '0;
        end else begin
            pending_q <= pending_nxt;
            cnt_q     <= cnt_nxt;
            if (fifo_empty || ld_gnt) begin
                starve_q <= '0;
            end else if (pipe_gnt && starve_q != SW'(STARVE_LIMIT)) begin
                starve_q <= starve_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_scheduler.sv
// Scoreboard bench for wb_scheduler: directed scenarios plus random traffic
// checked against a queue-based reference model of the arbitration rules.
module tb_wb_scheduler;
    import wb_scheduler_pkg::*;

    localparam int DEPTH = 2;
    localparam int MAXO  = 4;
    localparam int LIMIT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld_issue = 1'b0;
    logic [4:0]  ld_issue_rd = '0;
    logic        ld_issue_ready;
    logic        lsu_rvalid = 1'b0;
    logic [4:0]  lsu_rd = '0;
    logic [31:0] lsu_rdata = '0;
    logic        lsu_rready;
    logic        wb_req = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [1:0]  wb_src = WB_ALU;
    logic [4:0]  id_rs1 = '0;
    logic [4:0]  id_rs2 = '0;
    logic [1:0]  wb_sel;
    logic [31:0] ld_wdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        wb_stall;
    logic        raw_stall;
    logic [2:0]  pending_cnt;

    wb_scheduler #(.FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd), .ld_issue_ready(ld_issue_ready),
        .lsu_rvalid(lsu_rvalid), .lsu_rd(lsu_rd), .lsu_rdata(lsu_rdata), .lsu_rready(lsu_rready),
        .wb_req(wb_req), .wb_rd(wb_rd), .wb_src(wb_src),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .wb_sel(wb_sel), .ld_wdata(ld_wdata), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .wb_stall(wb_stall), .raw_stall(raw_stall), .pending_cnt(pending_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wb_req;
        logic [4:0]  wb_rd;
        logic [1:0]  wb_src;
        logic        ld_issue;
        logic [4:0]  ld_rd;
        logic        rvalid;
        logic [4:0]  lsu_rd;
        logic [31:0] lsu_data;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } stim_t;

    typedef struct { logic [4:0] rd; logic [31:0] data; } ret_m_t;
    typedef struct {
        int stamp; logic [1:0] sel; logic we; logic stall; logic raw;
        logic irdy; logic rrdy; int cnt; logic has_head; logic [31:0] head;
    } status_t;
    typedef struct { int stamp; logic [4:0] addr; logic [1:0] sel; logic is_ld; logic [31:0] data; } write_t;

    // Reference model state
    ret_m_t  fq[$];
    logic    pend[32];
    int      cnt;
    int      starve;
    logic [4:0] inflight[$];

    status_t sq[$];
    write_t  wq[$];
    int      cyc = 0;
    int      n_chk = 0;
    int      n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        fq.delete();
        inflight.delete();
        for (int i = 0; i < 32; i++) pend[i] = 1'b0;
        cnt = 0;
        starve = 0;
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.wb_src = WB_ALU;
        return s;
    endfunction

    task automatic drive_cycle(input stim_t s);
        status_t st;
        write_t  w;
        bit full, nonempty, ld_win, waw, pipe_win, iss, ready;
        @(posedge clk);
        #1;
        wb_req = s.wb_req; wb_rd = s.wb_rd; wb_src = s.wb_src;
        ld_issue = s.ld_issue; ld_issue_rd = s.ld_rd;
        lsu_rvalid = s.rvalid; lsu_rd = s.lsu_rd; lsu_rdata = s.lsu_data;
        id_rs1 = s.rs1; id_rs2 = s.rs2;

        full     = (fq.size() == DEPTH);
        nonempty = (fq.size() != 0);
        ld_win   = nonempty && (full || !s.wb_req || starve == LIMIT);
        waw      = s.wb_req && s.wb_rd != 0 && pend[s.wb_rd];
        pipe_win = !ld_win && s.wb_req && !waw;
        ready    = (cnt < MAXO) && !pend[s.ld_rd];
        iss      = s.ld_issue && ready;

        st.stamp = cyc;
        st.sel   = ld_win ? WB_LOAD : (pipe_win ? s.wb_src : WB_ALU);
        st.we    = ld_win ? (fq[0].rd != 0) : (pipe_win && s.wb_rd != 0);
        st.stall = s.wb_req && !pipe_win;
        st.raw   = (s.rs1 != 0 && pend[s.rs1]) || (s.rs2 != 0 && pend[s.rs2]);
        st.irdy  = ready;
        st.rrdy  = !full;
        st.cnt   = cnt;
        st.has_head = nonempty;
        st.head  = nonempty ? fq[0].data : 32'h0;
        sq.push_back(st);

        if (st.we) begin
            w.stamp = cyc;
            w.addr  = ld_win ? fq[0].rd : s.wb_rd;
            w.sel   = st.sel;
            w.is_ld = ld_win;
            w.data  = ld_win ? fq[0].data : 32'h0;
            wq.push_back(w);
        end

        // State as it will stand after the coming clock edge.
        if (!nonempty || ld_win) starve = 0;
        else if (pipe_win && starve < LIMIT) starve++;
        if (ld_win) begin
            pend[fq[0].rd] = 1'b0;
            void'(fq.pop_front());
        end
        if (s.rvalid && !full) begin
            fq.push_back('{rd: s.lsu_rd, data: s.lsu_data});
            for (int i = 0; i < inflight.size(); i++)
                if (inflight[i] == s.lsu_rd) begin inflight.delete(i); break; end
        end
        if (iss) begin
            if (s.ld_rd != 0) pend[s.ld_rd] = 1'b1;
            inflight.push_back(s.ld_rd);
        end
        if (iss && !ld_win) cnt++;
        else if (ld_win && !iss && cnt > 0) cnt--;
    endtask

    // Monitor: per-cycle status plus the write stream, decoupled from stimulus.
    always @(negedge clk) begin
        if (!rst) begin
            if (sq.size() > 0 && sq[0].stamp == cyc) begin
                status_t s;
                s = sq.pop_front();
                chk("wb_sel", 32'(wb_sel), 32'(s.sel));
                chk("rf_we", 32'(rf_we), 32'(s.we));
                chk("wb_stall", 32'(wb_stall), 32'(s.stall));
                chk("raw_stall", 32'(raw_stall), 32'(s.raw));
                chk("ld_issue_ready", 32'(ld_issue_ready), 32'(s.irdy));
                chk("lsu_rready", 32'(lsu_rready), 32'(s.rrdy));
                chk("pending_cnt", 32'(pending_cnt), 32'(s.cnt));
                if (s.has_head) chk("ld_wdata", ld_wdata, s.head);
            end
            while (wq.size() > 0 && wq[0].stamp < cyc) void'(wq.pop_front());
            if (rf_we === 1'b1) begin
                if (wq.size() > 0 && wq[0].stamp == cyc) begin
                    write_t w;
                    w = wq.pop_front();
                    chk("rf_waddr", 32'(rf_waddr), 32'(w.addr));
                    chk("write_sel", 32'(wb_sel), 32'(w.sel));
                    if (w.is_ld) chk("write_data", ld_wdata, w.data);
                end else begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_write: rf_we=1 addr %0d, none expected (cycle %0d)", rf_waddr, cyc);
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rf_we"}, 32'(rf_we), 32'h0);
        chk({tag, "_wb_stall"}, 32'(wb_stall), 32'h0);
        chk({tag, "_raw_stall"}, 32'(raw_stall), 32'h0);
        chk({tag, "_wb_sel"}, 32'(wb_sel), 32'(WB_ALU));
        chk({tag, "_lsu_rready"}, 32'(lsu_rready), 32'h1);
        chk({tag, "_ld_issue_ready"}, 32'(ld_issue_ready), 32'h1);
        chk({tag, "_rf_waddr"}, 32'(rf_waddr), 32'h0);
        chk({tag, "_ld_wdata"}, ld_wdata, 32'h0);
        chk({tag, "_pending_cnt"}, 32'(pending_cnt), 32'h0);
    endtask

    stim_t s;

    initial begin
        model_reset();
        wb_req = 1'b1; wb_rd = 5'd3; id_rs1 = 5'd3;
        #3;
        check_reset_outputs("reset");
        wb_req = 1'b0; wb_rd = '0; id_rs1 = '0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // Pipe write with empty FIFO
        s = idle(); s.wb_req = 1; s.wb_rd = 5; s.wb_src = WB_ALU; drive_cycle(s);
        // Load to x7, RAW, return, retire
        s = idle(); s.ld_issue = 1; s.ld_rd = 7; drive_cycle(s);
        s = idle(); s.rs1 = 7; drive_cycle(s);
        s = idle(); s.rs1 = 7; s.rvalid = 1; s.lsu_rd = 7; s.lsu_data = 32'hDEADBEEF; drive_cycle(s);
        s = idle(); drive_cycle(s);
        s = idle(); s.rs1 = 7; drive_cycle(s);
        // Fill FIFO under pipe pressure, then forced load win
        s = idle(); s.ld_issue = 1; s.ld_rd = 1; drive_cycle(s);
        s = idle(); s.ld_issue = 1; s.ld_rd = 2; drive_cycle(s);
        s = idle(); s.wb_req = 1; s.wb_rd = 3; s.rvalid = 1; s.lsu_rd = 1; s.lsu_data = 32'h1111; drive_cycle(s);
        s = idle(); s.wb_req = 1; s.wb_rd = 3; s.rvalid = 1; s.lsu_rd = 2; s.lsu_data = 32'h2222; drive_cycle(s);
        s = idle(); s.wb_req = 1; s.wb_rd = 4; s.wb_src = WB_PC4; s.ld_issue = 1; s.ld_rd = 6; drive_cycle(s);
        // Push and pop together keep occupancy
        s = idle(); s.rvalid = 1; s.lsu_rd = 6; s.lsu_data = 32'h6666; drive_cycle(s);
        s = idle(); drive_cycle(s);
        s = idle(); drive_cycle(s);
        // Starvation: one buffered return, pipe held high
        s = idle(); s.ld_issue = 1; s.ld_rd = 8; drive_cycle(s);
        s = idle(); s.wb_req = 1; s.wb_rd = 12; s.rvalid = 1; s.lsu_rd = 8; s.lsu_data = 32'h8888; drive_cycle(s);
        for (int i = 0; i < 4; i++) begin
            s = idle(); s.wb_req = 1; s.wb_rd = 12; s.wb_src = WB_PC4; drive_cycle(s);
        end
        // WAW stall on x9, refused reissue, max outstanding
        s = idle(); s.ld_issue = 1; s.ld_rd = 9; drive_cycle(s);
        s = idle(); s.wb_req = 1; s.wb_rd = 9; s.ld_issue = 1; s.ld_rd = 9; drive_cycle(s);
        s = idle(); s.wb_req = 1; s.wb_rd = 9; s.rvalid = 1; s.lsu_rd = 9; s.lsu_data = 32'h9999; drive_cycle(s);
        s = idle(); s.wb_req = 0; drive_cycle(s);
        s = idle(); s.wb_req = 1; s.wb_rd = 9; drive_cycle(s);
        for (int i = 0; i < 5; i++) begin
            s = idle(); s.ld_issue = 1; s.ld_rd = 5'(10 + i); drive_cycle(s);
        end
        s = idle(); s.ld_issue = 1; s.ld_rd = 0; drive_cycle(s);
        // Two buffered returns with loads pending, then reset mid-operation
        s = idle(); s.wb_req = 1; s.wb_rd = 20; s.rvalid = 1; s.lsu_rd = 10; s.lsu_data = 32'hA0; drive_cycle(s);
        s = idle(); s.wb_req = 1; s.wb_rd = 20; s.rvalid = 1; s.lsu_rd = 11; s.lsu_data = 32'hA1; drive_cycle(s);
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        wb_req = 1'b1; wb_rd = 5'd20; id_rs1 = 5'd12; id_rs2 = 5'd13;
        ld_issue = 1'b0; lsu_rvalid = 1'b0;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        @(posedge clk);
        #2;
        wb_req = 1'b0; id_rs1 = '0; id_rs2 = '0;
        #2 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s = idle(); s.rs1 = 12; drive_cycle(s);
        end

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            s = idle();
            s.wb_req = ($urandom_range(0, 99) < 60);
            s.wb_rd  = 5'($urandom_range(0, 15));
            s.wb_src = $urandom_range(0, 1) ? WB_PC4 : WB_ALU;
            s.ld_issue = ($urandom_range(0, 99) < 40);
            s.ld_rd  = 5'($urandom_range(0, 15));
            s.rs1    = 5'($urandom_range(0, 15));
            s.rs2    = 5'($urandom_range(0, 15));
            if (inflight.size() > 0 && fq.size() < DEPTH && $urandom_range(0, 1) == 1) begin
                s.rvalid   = 1;
                s.lsu_rd   = inflight[$urandom_range(0, inflight.size() - 1)];
                s.lsu_data = $urandom;
            end
            drive_cycle(s);
        end
        s = idle(); drive_cycle(s);
        @(negedge clk);
        #1;
        chk("status_drained", 32'(sq.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
